// File: rtl/unidade_controle_pkg.sv
// Shared constants and types for the processor control unit: opcodes,
// the T0..T3 step encoding and the instruction field positions within DIN/IR.
package uc_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int IR_W     = 9;

   localparam int III_HI = 8;
   localparam int III_LO = 6;
   localparam int XXX_HI = 5;
   localparam int XXX_LO = 3;
   localparam int YYY_HI = 2;
   localparam int YYY_LO = 0;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } step_t;

endpackage

// File: rtl/unidade_controle_if.sv
// Control bus between the control unit (master) and the register-file/ALU
// datapath (slave). Illegal exists only when UC_ILLEGAL_EN is defined.
interface unidade_controle_if;
   import uc_pkg::*;

   logic [DATA_W-1:0]   DIN;
   logic                Run;
   logic                IRin;
   logic [NUM_REGS-1:0] Rin;
   logic [NUM_REGS-1:0] Rout;
   logic                Ain;
   logic                Gin;
   logic                DINout;
   logic                Gout;
   logic                AddSub;
   logic                Done;
`ifdef UC_ILLEGAL_EN
   logic                Illegal;
`endif

   modport master (
      input  DIN, Run,
      output IRin, Rin, Rout, Ain, Gin, DINout, Gout, AddSub, Done
`ifdef UC_ILLEGAL_EN
      , output Illegal
`endif
   );

   modport slave (
      output DIN, Run,
      input  IRin, Rin, Rout, Ain, Gin, DINout, Gout, AddSub, Done
`ifdef UC_ILLEGAL_EN
      , input Illegal
`endif
   );

endinterface

// File: rtl/unidade_controle_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8 (
   input  logic       en,
   input  logic [2:0] sel,
   output logic [7:0] y
);

   assign y = en ? (8'b0000_0001 << sel) : 8'b0000_0000;

endmodule

// File: rtl/unidade_controle.sv
// Control unit: fetches a 9-bit instruction into IR and sequences T0..T3.
// Build option: define UC_ILLEGAL_EN to add the Illegal flag for opcodes 100-111.
module unidade_controle
   import uc_pkg::*;
(
   input  logic                      Clock,
   input  logic                      Resetn,
   unidade_controle_if.master        bus
);

   step_t          step;
   logic [IR_W-1:0] ir;
   logic [2:0]     op, rx, ry;
   logic           is_alu;

   assign op     = ir[III_HI:III_LO];
   assign rx     = ir[XXX_HI:XXX_LO];
   assign ry     = ir[YYY_HI:YYY_LO];
   assign is_alu = (op == OP_ADD) || (op == OP_SUB);

   // Only the instruction field bits of DIN are ever fetched.
   logic unused_din;
   assign unused_din = ^bus.DIN[DATA_W-1:IR_W];

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values; the IR is cleared on reset so a post-reset decode is defined.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         step <= T0;
         ir   <= '0;
      end else begin
         case (step)
            T0: if (bus.Run) begin
               ir   <= bus.DIN[IR_W-1:0];
               step <= T1;
            end
            T1: step <= is_alu ? T2 : T0;
            T2: step <= T3;
            T3: step <= T0;
         endcase
      end
   end

   logic       irin, ain, gin, dinout, gout, addsub, done, illegal_op;
   logic       rin_en, rout_en;
   logic [2:0] rout_sel;
   logic [NUM_REGS-1:0] rin, rout;

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      irin       = 1'b0;
      ain        = 1'b0;
      gin        = 1'b0;
      dinout     = 1'b0;
      gout       = 1'b0;
      addsub     = 1'b0;
      done       = 1'b0;
      illegal_op = 1'b0;
      rin_en     = 1'b0;
      rout_en    = 1'b0;
      rout_sel   = rx;
      case (step)
         T0: irin = bus.Run;
         T1: begin
            case (op)
               OP_MV: begin
                  rout_en  = 1'b1;
                  rout_sel = ry;
                  rin_en   = 1'b1;
                  done     = 1'b1;
               end
               OP_MVI: begin
                  dinout = 1'b1;
                  rin_en = 1'b1;
                  done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout_en = 1'b1;
                  ain     = 1'b1;
               end
               default: begin
                  done       = 1'b1;
                  illegal_op = 1'b1;
               end
            endcase
         end
         T2: if (is_alu) begin
            rout_en  = 1'b1;
            rout_sel = ry;
            gin      = 1'b1;
            addsub   = (op == OP_SUB);
         end
         T3: begin
            gout   = 1'b1;
            rin_en = 1'b1;
            done   = 1'b1;
         end
      endcase
   end

   dec3to8 u_dec_rin  (.en(rin_en),  .sel(rx),       .y(rin));
   dec3to8 u_dec_rout (.en(rout_en), .sel(rout_sel), .y(rout));

   assign bus.IRin   = irin;
   assign bus.Rin    = rin;
   assign bus.Rout   = rout;
   assign bus.Ain    = ain;
   assign bus.Gin    = gin;
   assign bus.DINout = dinout;
   assign bus.Gout   = gout;
   assign bus.AddSub = addsub;
   assign bus.Done   = done;

`ifdef UC_ILLEGAL_EN
   assign bus.Illegal = illegal_op;
`else
   logic unused_illegal;
   assign unused_illegal = illegal_op;
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: reset, mv/mvi/add/sub sequencing,
// back-to-back fetch with Run held, Run ignored outside T0, illegal opcodes.
module tb_unidade_controle;

   logic clk;
   logic resetn;
   int   checks;
   int   failures;

   localparam logic [6:0] C_IRIN   = 7'b100_0000;
   localparam logic [6:0] C_AIN    = 7'b010_0000;
   localparam logic [6:0] C_GIN    = 7'b001_0000;
   localparam logic [6:0] C_DINOUT = 7'b000_1000;
   localparam logic [6:0] C_GOUT   = 7'b000_0100;
   localparam logic [6:0] C_ADDSUB = 7'b000_0010;
   localparam logic [6:0] C_DONE   = 7'b000_0001;

   unidade_controle_if bus_if ();

   unidade_controle dut (
      .Clock  (clk),
      .Resetn (resetn),
      .bus    (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] ctrl_now();
      return {bus_if.IRin, bus_if.Ain, bus_if.Gin, bus_if.DINout,
              bus_if.Gout, bus_if.AddSub, bus_if.Done};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [7:0] rin,
                             input logic [7:0] rout, input logic [6:0] ctrl);
      check({tag, ".Rin"},  {8'h00, bus_if.Rin},  {8'h00, rin});
      check({tag, ".Rout"}, {8'h00, bus_if.Rout}, {8'h00, rout});
      check({tag, ".ctrl"}, {9'h000, ctrl_now()}, {9'h000, ctrl});
   endtask

   task automatic expect_illegal(input string tag, input logic exp);
`ifdef UC_ILLEGAL_EN
      check({tag, ".Illegal"}, {15'h0000, bus_if.Illegal}, {15'h0000, exp});
`else
      if (exp === 1'bx) $display("unreachable %s", tag);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      resetn     = 1'b0;
      bus_if.Run = 1'b0;
      bus_if.DIN = 16'h0000;
      #3;
      expect_out("reset", 8'h00, 8'h00, 7'h00);
      expect_illegal("reset", 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      tick();
      expect_out("idle_run0", 8'h00, 8'h00, 7'h00);

      // mvi R5,#0x00AB
      bus_if.DIN = 16'h0068;
      bus_if.Run = 1'b1;
      #1;
      expect_out("mvi.T0", 8'h00, 8'h00, C_IRIN);
      tick();
      bus_if.Run = 1'b0;
      bus_if.DIN = 16'h00AB;
      #1;
      expect_out("mvi.T1", 8'b0010_0000, 8'h00, C_DINOUT | C_DONE);
      expect_illegal("mvi.T1", 1'b0);
      tick();
      expect_out("mvi.after", 8'h00, 8'h00, 7'h00);

      // mv R1,R6
      bus_if.DIN = 16'h000E;
      bus_if.Run = 1'b1;
      tick();
      bus_if.Run = 1'b0;
      #1;
      expect_out("mv.T1", 8'b0000_0010, 8'b0100_0000, C_DONE);
      tick();
      expect_out("mv.after", 8'h00, 8'h00, 7'h00);

      // sub R0,R7 with a Run pulse in T2 that must be ignored
      bus_if.DIN = 16'h00C7;
      bus_if.Run = 1'b1;
      tick();
      bus_if.Run = 1'b0;
      #1;
      expect_out("sub.T1", 8'h00, 8'b0000_0001, C_AIN);
      bus_if.DIN = 16'h0000;
      tick();
      bus_if.Run = 1'b1;
      #1;
      expect_out("sub.T2", 8'h00, 8'b1000_0000, C_GIN | C_ADDSUB);
      tick();
      bus_if.Run = 1'b0;
      #1;
      expect_out("sub.T3", 8'b0000_0001, 8'h00, C_GOUT | C_DONE);
      tick();
      expect_out("sub.after", 8'h00, 8'h00, 7'h00);

      // add R2,R2 then mv R3,R4 with Run held high throughout
      bus_if.DIN = 16'h0092;
      bus_if.Run = 1'b1;
      tick();
      expect_out("add.T1", 8'h00, 8'b0000_0100, C_AIN);
      tick();
      expect_out("add.T2", 8'h00, 8'b0000_0100, C_GIN);
      tick();
      bus_if.DIN = 16'h001C;
      #1;
      expect_out("add.T3", 8'b0000_0100, 8'h00, C_GOUT | C_DONE);
      tick();
      expect_out("b2b.T0", 8'h00, 8'h00, C_IRIN);
      tick();
      bus_if.Run = 1'b0;
      #1;
      expect_out("b2b.mv.T1", 8'b0000_1000, 8'b0001_0000, C_DONE);
      tick();
      expect_out("b2b.after", 8'h00, 8'h00, 7'h00);

      // opcode 111
      bus_if.DIN = 16'h01C0;
      bus_if.Run = 1'b1;
      tick();
      bus_if.Run = 1'b0;
      #1;
      expect_out("ill.T1", 8'h00, 8'h00, C_DONE);
      expect_illegal("ill.T1", 1'b1);
      tick();
      expect_out("ill.after", 8'h00, 8'h00, 7'h00);
      expect_illegal("ill.after", 1'b0);

      // add R4,R1 aborted by reset in T2
      bus_if.DIN = 16'h00A1;
      bus_if.Run = 1'b1;
      tick();
      bus_if.Run = 1'b0;
      tick();
      expect_out("abort.T2", 8'h00, 8'b0000_0010, C_GIN);
      #2;
      resetn = 1'b0;
      #1;
      expect_out("abort.async", 8'h00, 8'h00, 7'h00);
      tick();
      expect_out("abort.held", 8'h00, 8'h00, 7'h00);
      @(negedge clk);
      resetn = 1'b1;
      tick();
      expect_out("abort.rel1", 8'h00, 8'h00, 7'h00);
      tick();
      expect_out("abort.rel2", 8'h00, 8'h00, 7'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Control unit of the simple 16-bit processor: fetches a 9-bit instruction from the DIN bus into an internal instruction register and sequences it over one to three execution steps. It drives the load enables (`Rin`) of the eight 16-bit general registers and the A/G registers, the bus-multiplexer selects, and the ALU add/subtract select. It sits directly upstream of the register file. Registers capture on the negative clock edge, so every enable from this block is valid for the whole cycle in which they sample it.

## Interface
- No parameters: data width is fixed at 16 bits, with 8 general registers.
- `Clock`  in  1  — single clock; state advances on the rising edge.
- `Resetn`  in  1  — asynchronous, active-low reset.
- `DIN`  in  16  — instruction/immediate bus. Instruction fields: `III` = DIN[8:6], `XXX` = DIN[5:3], `YYY` = DIN[2:0].
- `Run`  in  1  — start request, sampled only in T0.
- `IRin`  out  1  — IR load strobe (observability).
- `Rin`  out  8  — one-hot load enables for R0..R7.
- `Rout`  out  8  — one-hot bus-drive selects for R0..R7.
- `Ain`, `Gin`  out  1 each  — A and G register load enables.
- `DINout`, `Gout`  out  1 each  — bus-drive selects for DIN and G.
- `AddSub`  out  1  — ALU operation: 0 = add, 1 = subtract.
- `Done`  out  1  — high in the final step of each instruction.
- `Illegal`  out  1  — present only when `UC_ILLEGAL_EN` is defined.

## Operation
- Step counter states: T0 (fetch/idle), T1, T2, T3. The 2-bit counter and the 9-bit IR are the only flops.
- T0: `IRin` = `Run`. On a rising edge with `Run`=1: IR <= DIN[8:0] and the state moves to T1. With `Run`=0 the state stays in T0 and IR holds.
- Opcode 000 `mv Rx,Ry` — T1: `Rout[Y]`, `Rin[X]`, `Done`; then T0.
- Opcode 001 `mvi Rx,#D` — T1: `DINout`, `Rin[X]`, `Done`; then T0. DIN carries the immediate during T1.
- Opcode 010 `add` / 011 `sub` `Rx,Ry`:
  - T1: `Rout[X]`, `Ain`.
  - T2: `Rout[Y]`, `Gin`, `AddSub` = 1 for sub only.
  - T3: `Gout`, `Rin[X]`, `Done`; then T0.
- Opcodes 100–111: T1: `Done` only, with no bus drive and no register load; then T0.
- Outputs are a combinational decode of state and IR. All outputs not listed for a step are 0.
- `Rin` and `Rout` are one-hot or all-zero. At most one bus-drive source (`Rout`, `DINout`, `Gout`) is active in any cycle.
- `X` = `Y` is legal. For example `add R2,R2` doubles R2, and `mv R3,R3` is harmless.
- `Run` is ignored outside T0. Holding `Run` high causes back-to-back fetches: the next T0 after `Done` fetches immediately.

## Timing
- Reset (asynchronous assert, at any time): state = T0, IR = 0, and every output = 0 in that cycle (`Run` is assumed low during reset).
- Reset asserted mid-instruction aborts it: no further `Rin` is issued, and the destination keeps whatever it last captured.
- Reset release is synchronous to the next rising edge; the first fetch is possible on the first edge after release.
- Latency from the fetch edge to `Done` high: 1 cycle for mv, mvi and illegal opcodes; 3 cycles for add/sub.
- Total cycles per instruction, including T0: 2 for mv/mvi, 4 for add/sub.
- `Done` is high for exactly one cycle per instruction.
- `DIN` must be stable around the fetch edge, and for the whole T1 cycle for mvi.

## Configuration
- `UC_ILLEGAL_EN` defined:
  - Port `Illegal` exists.
  - `Illegal` is high together with `Done` in T1 for opcodes 100–111, and 0 otherwise.
  - Reset value is 0.
- `UC_ILLEGAL_EN` undefined:
  - No `Illegal` port.
  - Opcodes 100–111 are silent no-ops that still assert `Done`.

## Structure
- Shared package `uc_pkg` holds:
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`;
  - a 2-bit step typedef with T0–T3;
  - the IR field bit positions.
- One sub-module, `dec3to8`: a 3-to-8 one-hot decoder with an enable input. It is instantiated twice, for X → `Rin` and for Y/X → `Rout`.

## Test plan
- Reset mid-add, with the async `Resetn` low in T2 → all outputs 0 immediately; state T0; no `Rin` pulse follows after release.
- `mvi R5,#0x00AB` (DIN = 0x0068, then 0x00AB during T1) → T1 shows `DINout`=1, `Rin`=8'b0010_0000, `Done`=1; the next cycle is T0.
- `mv R1,R6` (DIN = 0x000E) → T1 shows `Rout`=8'b0100_0000, `Rin`=8'b0000_0010, `Done`=1, with no other enables.
- `sub R0,R7` (DIN = 0x00C7) → T1: `Rout[0]`, `Ain`; T2: `Rout[7]`, `Gin`, `AddSub`=1; T3: `Gout`, `Rin[0]`, `Done`.
- `Run` held high across `add` then `mv` → the second fetch happens on the edge right after T3. `Run` pulsed during T2 has no effect.
- Opcode 111 (DIN = 0x01C0) → T1 `Done`=1 with all enables 0. `Illegal`=1 only when built with `UC_ILLEGAL_EN`.
